// File: rtl/instr_assembler.sv
// Packs MIPS R/I/J field groups into 32-bit words, queues them in a small FIFO and streams
// them into instruction memory at an auto-incrementing word address. Define ASM_COUNT_EN to add word_count.
module instr_assembler #(
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned ADDR_W    = 10,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_last,
    input  logic [1:0]        fmt,
    input  logic [5:0]        op,
    input  logic [4:0]        rs,
    input  logic [4:0]        rt,
    input  logic [4:0]        rd,
    input  logic [4:0]        shamt,
    input  logic [5:0]        funct,
    input  logic [15:0]       imm,
    input  logic [25:0]       target,
    output logic              im_we,
    input  logic              im_ready,
    output logic [ADDR_W-1:0] im_addr,
    output logic [31:0]       im_wdata,
    output logic              done,
    output logic              fmt_err
`ifdef ASM_COUNT_EN
    ,
    output logic [ADDR_W:0]   word_count
`endif
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic [0:0] {
        RUN  = 1'b0,
        DONE = 1'b1
    } state_t;

    // Illegal formats collapse to a nop so the program image keeps its word alignment.
    function automatic logic [31:0] pack_word(
        input logic [1:0]  f_fmt,
        input logic [5:0]  f_op,
        input logic [4:0]  f_rs,
        input logic [4:0]  f_rt,
        input logic [4:0]  f_rd,
        input logic [4:0]  f_shamt,
        input logic [5:0]  f_funct,
        input logic [15:0] f_imm,
        input logic [25:0] f_target
    );
        logic [31:0] w;
        case (f_fmt)
            2'b00:   w = {f_op, f_rs, f_rt, f_rd, f_shamt, f_funct};
            2'b01:   w = {f_op, f_rs, f_rt, f_imm};
            2'b10:   w = {f_op, f_target};
            default: w = 32'h0000_0000;
        endcase
        return w;
    endfunction

    state_t            state_r;
    logic [32:0]       mem_r [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_r;
    logic [PTR_W-1:0]  rd_ptr_r;
    logic [CNT_W-1:0]  count_r;
    logic [ADDR_W-1:0] addr_r;
    logic              done_r;
    logic              fmt_err_r;
`ifdef ASM_COUNT_EN
    logic [ADDR_W:0]   word_count_r;
`endif

    logic              full_s;
    logic              empty_s;
    logic              push_s;
    logic              pop_s;
    logic [31:0]       word_s;
    logic [32:0]       head_s;

    // Handshakes and IM-side outputs derived from FIFO occupancy and state.
    always_comb begin
        word_s  = pack_word(fmt, op, rs, rt, rd, shamt, funct, imm, target);
        head_s  = mem_r[rd_ptr_r];
        full_s  = (count_r == CNT_W'(DEPTH));
        empty_s = (count_r == {CNT_W{1'b0}});
        if (state_r == RUN) begin
            in_ready = !full_s;
            im_we    = !empty_s;
        end else begin
            in_ready = 1'b0;
            im_we    = 1'b0;
        end
        push_s = in_valid && in_ready;
        pop_s  = im_we && im_ready;
        if (im_we) begin
            im_wdata = head_s[31:0];
        end else begin
            im_wdata = 32'h0000_0000;
        end
        im_addr = addr_r;
        done    = done_r;
        fmt_err = fmt_err_r;
`ifdef ASM_COUNT_EN
        word_count = word_count_r;
`endif
    end

    // FIFO pointers, address counter and RUN/DONE sequencing.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= RUN;
            wr_ptr_r  <= {PTR_W{1'b0}};
            rd_ptr_r  <= {PTR_W{1'b0}};
            count_r   <= {CNT_W{1'b0}};
            addr_r    <= ADDR_W'(BASE_ADDR);
            done_r    <= 1'b0;
            fmt_err_r <= 1'b0;
`ifdef ASM_COUNT_EN
            word_count_r <= {(ADDR_W+1){1'b0}};
`endif
        end else begin
            done_r <= 1'b0;
            if (push_s) begin
                mem_r[wr_ptr_r] <= {in_last, word_s};
                wr_ptr_r        <= wr_ptr_r + PTR_W'(1'b1);
                if (fmt == 2'b11) begin
                    fmt_err_r <= 1'b1;
                end
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1'b1);
                addr_r   <= addr_r + ADDR_W'(1'b1);
                if (head_s[32]) begin
                    state_r <= DONE;
                    done_r  <= 1'b1;
                end
`ifdef ASM_COUNT_EN
                if (word_count_r != {(ADDR_W+1){1'b1}}) begin
                    word_count_r <= word_count_r + (ADDR_W+1)'(1'b1);
                end
`endif
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1'b1);
                2'b01:   count_r <= count_r - CNT_W'(1'b1);
                default: count_r <= count_r;
            endcase
            // A quiet input cycle releases DONE; the address is kept so the next program appends.
            if (state_r == DONE && !in_valid) begin
                state_r <= RUN;
            end
        end
    end

endmodule

// File: tb/tb_instr_assembler.sv
// Scoreboard bench for instr_assembler: accepted field groups are packed by an arithmetic
// reference model and queued; a monitor compares every IM write, handshake and status flag.
module tb_instr_assembler;

    localparam int DEPTH  = 4;
    localparam int ADDR_W = 10;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              reset;
    logic              in_valid;
    logic              in_ready;
    logic              in_last;
    logic [1:0]        fmt;
    logic [5:0]        op;
    logic [4:0]        rs;
    logic [4:0]        rt;
    logic [4:0]        rd;
    logic [4:0]        shamt;
    logic [5:0]        funct;
    logic [15:0]       imm;
    logic [25:0]       target;
    logic              im_we;
    logic              im_ready;
    logic [ADDR_W-1:0] im_addr;
    logic [31:0]       im_wdata;
    logic              done;
    logic              fmt_err;
`ifdef ASM_COUNT_EN
    logic [ADDR_W:0]   word_count;
`endif

    logic rdy_dir;
    logic rdy_rand = 1'b1;
    logic rand_rdy_en;
    assign im_ready = rand_rdy_en ? rdy_rand : rdy_dir;

    instr_assembler #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .BASE_ADDR(0)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
        .fmt(fmt), .op(op), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt), .funct(funct),
        .imm(imm), .target(target), .im_we(im_we), .im_ready(im_ready), .im_addr(im_addr),
        .im_wdata(im_wdata), .done(done), .fmt_err(fmt_err)
`ifdef ASM_COUNT_EN
        , .word_count(word_count)
`endif
    );

    typedef struct {
        logic [31:0] word;
        logic        last;
    } exp_t;

    exp_t acc_q[$];
    int   acc_base    = 0;
    logic fmt_err_nxt = 1'b0;
    logic fmt_err_vis = 1'b0;

    int   n_checks = 0;
    int   n_fail   = 0;

    int   rd_idx    = 0;
    int   exp_addr  = 0;
    int   wc_m      = 0;
    logic in_done_m = 1'b0;
    logic done_m    = 1'b0;
    logic started   = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference encoder: field weights as plain powers of two.
    function automatic logic [31:0] ref_pack(input logic [1:0] f, input logic [5:0] o,
                                             input logic [4:0] s, input logic [4:0] t,
                                             input logic [4:0] d, input logic [4:0] sh,
                                             input logic [5:0] fn, input logic [15:0] im,
                                             input logic [25:0] tg);
        longint w;
        w = 0;
        if (f == 2'd0) w = o * 64'd67108864 + s * 64'd2097152 + t * 64'd65536 + d * 64'd2048 + sh * 64'd64 + fn;
        else if (f == 2'd1) w = o * 64'd67108864 + s * 64'd2097152 + t * 64'd65536 + im;
        else if (f == 2'd2) w = o * 64'd67108864 + tg;
        return w[31:0];
    endfunction

    // Acceptance logger: records every handshake the DUT takes at the coming edge.
    always @(negedge clk) begin
        acc_base    <= acc_q.size();
        fmt_err_vis <= fmt_err_nxt;
        if (reset) begin
            fmt_err_nxt <= 1'b0;
        end else if (in_valid && in_ready) begin
            acc_q.push_back('{ref_pack(fmt, op, rs, rt, rd, shamt, funct, imm, target), in_last});
            if (fmt == 2'b11) fmt_err_nxt <= 1'b1;
        end
    end

    // Monitor: compares DUT outputs with the model, then advances the model.
    always begin : mon
        int   occ;
        logic exp_we;
        logic exp_rdy;
        @(negedge clk);
        #1;
        occ     = acc_base - rd_idx;
        exp_we  = (occ > 0) && !in_done_m;
        exp_rdy = (occ < DEPTH) && !in_done_m;
        if (started) begin
            check("im_we", im_we, exp_we);
            check("in_ready", in_ready, exp_rdy);
            check("done", done, done_m);
            check("fmt_err", fmt_err, fmt_err_vis);
`ifdef ASM_COUNT_EN
            check("word_count", word_count, wc_m);
`endif
            if (exp_we && im_we) begin
                check("im_wdata", im_wdata, acc_q[rd_idx].word);
                check("im_addr", im_addr, exp_addr);
            end
        end
        if (reset) begin
            rd_idx    = acc_q.size();
            exp_addr  = 0;
            wc_m      = 0;
            in_done_m = 1'b0;
            done_m    = 1'b0;
            started   = 1'b1;
        end else if (in_done_m) begin
            done_m = 1'b0;
            if (!in_valid) in_done_m = 1'b0;
        end else begin
            done_m = 1'b0;
            if (exp_we && im_ready) begin
                if (acc_q[rd_idx].last) begin
                    in_done_m = 1'b1;
                    done_m    = 1'b1;
                end
                rd_idx++;
                exp_addr = (exp_addr + 1) % (1 << ADDR_W);
                if (wc_m < (1 << (ADDR_W + 1)) - 1) wc_m++;
            end
        end
    end

    initial forever begin
        @(posedge clk);
        #1;
        rdy_rand = ($urandom_range(0, 3) != 0);
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic push_fields(input logic [1:0] f, input logic [5:0] o, input logic [4:0] s,
                               input logic [4:0] t, input logic [4:0] d, input logic [4:0] sh,
                               input logic [5:0] fn, input logic [15:0] im, input logic [25:0] tg,
                               input logic last);
        logic ok;
        fmt = f; op = o; rs = s; rt = t; rd = d; shamt = sh; funct = fn; imm = im; target = tg;
        in_last  = last;
        in_valid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 64 && !ok; i++) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
        end
        check("push_accept", ok, 1'b1);
        in_valid = 1'b0;
    endtask

    task automatic push_rand(input logic [1:0] f, input logic last, output logic [31:0] w);
        logic [5:0] o, fn;
        logic [4:0] s, t, d, sh;
        logic [15:0] im;
        logic [25:0] tg;
        o = 6'($urandom); s = 5'($urandom); t = 5'($urandom); d = 5'($urandom);
        sh = 5'($urandom); fn = 6'($urandom); im = 16'($urandom); tg = 26'($urandom);
        w = ref_pack(f, o, s, t, d, sh, fn, im, tg);
        push_fields(f, o, s, t, d, sh, fn, im, tg, last);
    endtask

    task automatic wait_drain(input string name);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 400 && !ok; i++) begin
            if (acc_q.size() == rd_idx && !in_done_m) ok = 1'b1;
            else begin
                @(posedge clk);
                #1;
            end
        end
        check(name, ok, 1'b1);
    endtask

    task automatic wait_write(input logic [31:0] w, input logic [31:0] a, input string name);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 32 && !ok; i++) begin
            @(negedge clk);
            #2;
            if (im_we && im_ready) begin
                ok = 1'b1;
                check({name, "_data"}, im_wdata, w);
                check({name, "_addr"}, im_addr, a);
            end
            @(posedge clk);
            #1;
        end
        check({name, "_seen"}, ok, 1'b1);
    endtask

    initial begin
        logic [31:0] w0, wx;
        int npulse;
        reset = 1'b1; in_valid = 1'b0; in_last = 1'b0; fmt = 2'b00;
        op = 6'd0; rs = 5'd0; rt = 5'd0; rd = 5'd0; shamt = 5'd0; funct = 6'd0;
        imm = 16'd0; target = 26'd0; rdy_dir = 1'b1; rand_rdy_en = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        @(negedge clk);
        check("rst_wdata", im_wdata, 32'h0);
        check("rst_addr", im_addr, 32'h0);
        check("rst_in_ready", in_ready, 1'b1);
        @(posedge clk);
        #1;

        // R-type addu $t2,$t0,$t1
        push_fields(2'b00, 6'h00, 5'd8, 5'd9, 5'd10, 5'd0, 6'h21, 16'h0, 26'h0, 1'b0);
        wait_write(32'h0109_5021, 32'd0, "r_type");

        // ori then j, held back so both writes are observed in order
        do_reset();
        rdy_dir = 1'b0;
        push_fields(2'b01, 6'h0d, 5'd0, 5'd8, 5'd0, 5'd0, 6'h0, 16'h1234, 26'h0, 1'b0);
        push_fields(2'b10, 6'h02, 5'd0, 5'd0, 5'd0, 5'd0, 6'h0, 16'h0, 26'h000_0c00, 1'b0);
        rdy_dir = 1'b1;
        wait_write(32'h3408_1234, 32'd0, "i_type");
        wait_write(32'h0800_0c00, 32'd1, "j_type");

        // backpressure: fifth word waits until a write drains
        do_reset();
        rdy_dir = 1'b0;
        push_rand(2'b00, 1'b0, w0);
        for (int i = 0; i < 3; i++) push_rand(2'($urandom_range(0, 2)), 1'b0, wx);
        fork
            push_rand(2'b01, 1'b0, wx);
            begin
                repeat (3) begin
                    @(negedge clk);
                    #2;
                    check("bp_in_ready", in_ready, 1'b0);
                    check("bp_hold_data", im_wdata, w0);
                end
                @(posedge clk);
                #1;
                rdy_dir = 1'b1;
            end
        join
        wait_drain("bp_drain");

        // in_last on the third word
        do_reset();
        push_rand(2'b00, 1'b0, wx);
        push_rand(2'b01, 1'b0, wx);
        push_rand(2'b10, 1'b1, wx);
        in_last  = 1'b0;
        in_valid = 1'b1;
        npulse = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            #2;
            if (done) npulse++;
        end
        check("done_pulses", npulse, 1);
        check("done_in_ready", in_ready, 1'b0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        wait_drain("done_drain");
        push_rand(2'b00, 1'b0, wx);
        wait_drain("append_drain");

        // illegal format becomes a nop and sets the sticky flag
        do_reset();
        push_rand(2'b11, 1'b0, wx);
        wait_drain("nop_drain");
        check("fmt_err_set", fmt_err, 1'b1);
        push_rand(2'b00, 1'b0, wx);
        wait_drain("legal_drain");
        check("fmt_err_sticky", fmt_err, 1'b1);
        do_reset();
        @(negedge clk);
        check("fmt_err_clr", fmt_err, 1'b0);
        check("clr_addr", im_addr, 32'h0);
        @(posedge clk);
        #1;

        // reset with words queued discards them
        rdy_dir = 1'b0;
        push_rand(2'b00, 1'b0, wx);
        push_rand(2'b01, 1'b0, wx);
        do_reset();
        rdy_dir = 1'b1;
        repeat (5) begin
            @(negedge clk);
            #2;
            check("flush_no_we", im_we, 1'b0);
        end
        @(posedge clk);
        #1;

        // random traffic, long enough to wrap the address counter
        rand_rdy_en = 1'b1;
        for (int n = 0; n < 1100; n++) begin
            logic [1:0] f;
            logic       lst;
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
            f   = ($urandom_range(0, 15) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            lst = ($urandom_range(0, 63) == 0);
            push_rand(f, lst, wx);
            if (lst) wait_drain("rand_last_drain");
        end
        rand_rdy_en = 1'b0;
        rdy_dir     = 1'b1;
        wait_drain("final_drain");
        repeat (2) @(posedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/instr_assembler.md
Name: instr_assembler

Overview:
- Inverse of the instruction field splitter: packs decoded MIPS field groups (R/I/J format) into 32-bit instruction words.
- Buffers packed words in a small FIFO.
- Streams the words into instruction memory through a write port with an auto-incrementing word address.
- Used by the test/boot loader path to build IM contents from field-level stimulus before the CPU is released from reset.

Parameters:
- DEPTH, 4, FIFO entries; power of two, ≥2.
- ADDR_W, 10, IM word-address width.
- BASE_ADDR, 0, first IM word address written after reset.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high
- in_valid  input  1  field group present
- in_ready  output  1  FIFO can accept (not full)
- in_last  input  1  marks final instruction of program
- fmt  input  2  00=R, 01=I, 10=J, 11=illegal
- op  input  6  bits 31:26
- rs  input  5  bits 25:21
- rt  input  5  bits 20:16
- rd  input  5  bits 15:11
- shamt  input  5  bits 10:6
- funct  input  6  bits 5:0
- imm  input  16  bits 15:0 (I)
- target  input  26  bits 25:0 (J)
- im_we  output  1  IM write strobe
- im_ready  input  1  IM accepts write this cycle
- im_addr  output  ADDR_W  word address
- im_wdata  output  32  packed instruction
- done  output  1  one-cycle pulse after last word written
- fmt_err  output  1  sticky: illegal fmt seen

Behaviour:
- Encoding (combinational at input):
  - R = {op,rs,rt,rd,shamt,funct}
  - I = {op,rs,rt,imm}
  - J = {op,target}
  - fmt 11 → word 32'h0000_0000 (nop) is enqueued and fmt_err is set.
  - Unused fields are ignored.
- Input handshake: an entry is accepted when in_valid && in_ready. The packed word and in_last are stored together. in_ready = !full, registered-free (comb from count).
- Output handshake:
  - im_we = !empty && state != DONE.
  - im_wdata/im_addr come from the FIFO head and the address counter.
  - A write completes when im_we && im_ready; on completion the FIFO pops and im_addr increments, wrapping from 2^ADDR_W-1 to 0.
  - im_wdata/im_addr hold stable while im_we && !im_ready.
- Latency: a word accepted in cycle N is visible on im_we at N+1 at the earliest.
- Simultaneous push and pop when full: push refused (in_ready=0); pop proceeds.
- Simultaneous push and pop when non-full, non-empty: count unchanged.
- Empty: im_we=0; a push into an empty FIFO does not bypass.
- States:
  - RUN: normal operation.
  - DONE: entered when the popped entry has last=1. done pulses high for exactly the cycle after that pop. In DONE, in_ready=0 and im_we=0. DONE→RUN when in_valid is low for one cycle; im_addr keeps its value, so a new program appends.
- Reset (synchronous, any state, mid-transfer included):
  - FIFO emptied; state RUN.
  - im_addr=BASE_ADDR; im_we=0; im_wdata=0; done=0; fmt_err=0; in_ready=1.
- fmt_err clears only on reset.

Optional Feature:
- Macro ASM_COUNT_EN.
- Defined: adds output port word_count (ADDR_W+1 bits), counting completed IM writes since reset. It saturates at all-ones and is unaffected by DONE. Reset value 0.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- R-type: fmt=00, op=0, rs=8, rt=9, rd=10, shamt=0, funct=6'h21, im_ready=1 → next cycle im_we=1, im_addr=0, im_wdata=32'h0109_5021.
- I then J: ori $t0,$0,0x1234 (op=6'h0d, rs=0, rt=8, imm=16'h1234) then j target=26'h0000_0c00 (op=2) → writes 32'h3408_1234 @0, 32'h0800_0c00 @1.
- Backpressure: im_ready=0, push 5 words with DEPTH=4 → in_ready drops after 4th accept; 5th held; im_wdata stable. im_ready=1 → 5 writes at addresses 0..4 in order.
- in_last on 3rd word → done pulses once, the cycle after the write @2; in_ready=0 until in_valid is low for one cycle.
- fmt=11 → nop 32'h0 written; fmt_err=1 and stays 1. reset → fmt_err=0, im_addr=BASE_ADDR, FIFO empty.
- Wrap: ADDR_W=2, 5 writes → addresses 0,1,2,3,0. Reset asserted with 2 words queued → no further im_we.
